four_12_12_st0_fwd: RTL and testbench

Forward-pass sequencer and MAC stage directly downstream of the stage-0 tap/bias/data memories. On start it reads, for each of N_OUT output neurons, one tap row, one bias word and N_IN input data words. It then computes the saturated Q16.16 dot product plus bias and streams one result per neuron over a valid/ready port to the next stage.

---
 rtl/four_12_12_st0_fwd.sv | 249 ++++++++++++++++++++++++
 tb/tb_four_12_12_st0_fwd.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_12_12_st0_fwd.sv
// Stage-0 forward sequencer: fetches tap row, bias and inputs per neuron, runs a
// signed Q16.16 MAC and streams one saturated result per neuron over valid/ready.
module four_12_12_st0_fwd #(
    parameter int N_IN      = 12,
    parameter int N_OUT     = 12,
    parameter int FRAC      = 16,
    parameter int DATA_BASE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 tap_rd_en,
    output logic [4:0]           tap_rd_addr,
    input  logic [32*N_IN-1:0]   tap_rd_data,
    output logic                 bias_rd_en,
    output logic [3:0]           bias_rd_addr,
    input  logic [31:0]          bias_rd_data,
    output logic                 data_rd_en,
    output logic [8:0]           data_rd_addr,
    input  logic [31:0]          data_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [3:0]           out_index,
    output logic                 done
);

    localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int AW = 68;
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        FIN  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Clamp a wide signed value into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [AW-1:0] v);
        logic [31:0] r;
        if (!v[AW-1] && (|v[AW-2:31])) begin
            r = 32'h7FFF_FFFF;
        end else if (v[AW-1] && !(&v[AW-2:31])) begin
            r = 32'h8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    state_t                  state_r, state_s;
    logic [NW-1:0]           n_r, n_s;
    logic [KW-1:0]           k_r, k_s;
    logic signed [AW-1:0]    acc_r, acc_s;
    logic [32*N_IN-1:0]      tap_row_r, tap_row_s;
    logic [31:0]             bias_r, bias_s;
    logic                    out_valid_r, out_valid_s;
    logic [31:0]             out_data_r, out_data_s;
    logic [3:0]              out_index_r, out_index_s;
    logic                    done_r, done_s;
    logic                    busy_r;
    logic                    tap_rd_en_r, tap_rd_en_s;
    logic [4:0]              tap_rd_addr_r, tap_rd_addr_s;
    logic                    bias_rd_en_r, bias_rd_en_s;
    logic [3:0]              bias_rd_addr_r, bias_rd_addr_s;
    logic                    data_rd_en_r, data_rd_en_s;
    logic [8:0]              data_rd_addr_r, data_rd_addr_s;

    logic [31:0]             tap_sel_s;
    logic [31:0]             tap_elem_s;
    logic signed [63:0]      prod_s;
    logic signed [AW-1:0]    acc_shr_s;
    logic signed [AW-1:0]    fin_sum_s;

    // Select tap element k from the latched row.
    always_comb begin
        tap_sel_s = 32'd0;
        for (int i = 0; i < N_IN; i++) begin
            tap_sel_s = (k_r == KW'(i)) ? tap_row_r[32*i +: 32] : tap_sel_s;
        end
    end

    // At k==0 the row is still on the memory bus, so bypass the register.
    assign tap_elem_s = (k_r == {KW{1'b0}}) ? tap_rd_data[31:0] : tap_sel_s;
    assign prod_s     = $signed({{32{tap_elem_s[31]}}, tap_elem_s})
                      * $signed({{32{data_rd_data[31]}}, data_rd_data});
    assign acc_shr_s  = acc_r >>> FRAC;
    assign fin_sum_s  = acc_shr_s + $signed({{(AW-32){bias_r[31]}}, bias_r});

    // Next-state, datapath and result-register update.
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        k_s         = k_r;
        acc_s       = acc_r;
        tap_row_s   = tap_row_r;
        bias_s      = bias_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_index_s = out_index_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD;
                    n_s     = {NW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                k_s     = {KW{1'b0}};
                acc_s   = {AW{1'b0}};
                state_s = MAC;
            end
            MAC: begin
                if (k_r == {KW{1'b0}}) begin
                    tap_row_s = tap_rd_data;
                    bias_s    = bias_rd_data;
                end else begin
                    tap_row_s = tap_row_r;
                    bias_s    = bias_r;
                end
                acc_s = acc_r + $signed({{(AW-64){prod_s[63]}}, prod_s});
                if (k_r == K_LAST) begin
                    state_s = FIN;
                end else begin
                    k_s = k_r + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            FIN: begin
                out_data_s  = sat32(fin_sum_s);
                out_index_s = 4'(n_r);
                out_valid_s = 1'b1;
                state_s     = OUT;
            end
            OUT: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    if (n_r == N_LAST) begin
                        done_s  = 1'b1;
                        n_s     = {NW{1'b0}};
                        state_s = IDLE;
                    end else begin
                        n_s     = n_r + {{(NW-1){1'b0}}, 1'b1};
                        state_s = LOAD;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Memory strobes are registered, so they are decoded from the state being entered.
    always_comb begin
        tap_rd_en_s    = 1'b0;
        tap_rd_addr_s  = 5'd0;
        bias_rd_en_s   = 1'b0;
        bias_rd_addr_s = 4'd0;
        data_rd_en_s   = 1'b0;
        data_rd_addr_s = 9'd0;
        case (state_s)
            LOAD: begin
                tap_rd_en_s    = 1'b1;
                tap_rd_addr_s  = 5'(n_s);
                bias_rd_en_s   = 1'b1;
                bias_rd_addr_s = 4'(n_s);
                data_rd_en_s   = 1'b1;
                data_rd_addr_s = 9'(DATA_BASE);
            end
            MAC: begin
                if (k_s < K_LAST) begin
                    data_rd_en_s   = 1'b1;
                    data_rd_addr_s = 9'(DATA_BASE) + 9'(k_s) + 9'd1;
                end else begin
                    data_rd_en_s   = 1'b0;
                    data_rd_addr_s = 9'd0;
                end
            end
            default: begin
                data_rd_en_s   = 1'b0;
                data_rd_addr_s = 9'd0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= IDLE;
            n_r            <= {NW{1'b0}};
            k_r            <= {KW{1'b0}};
            acc_r          <= {AW{1'b0}};
            tap_row_r      <= {(32*N_IN){1'b0}};
            bias_r         <= 32'd0;
            out_valid_r    <= 1'b0;
            out_data_r     <= 32'd0;
            out_index_r    <= 4'd0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            tap_rd_en_r    <= 1'b0;
            tap_rd_addr_r  <= 5'd0;
            bias_rd_en_r   <= 1'b0;
            bias_rd_addr_r <= 4'd0;
            data_rd_en_r   <= 1'b0;
            data_rd_addr_r <= 9'd0;
        end else begin
            state_r        <= state_s;
            n_r            <= n_s;
            k_r            <= k_s;
            acc_r          <= acc_s;
            tap_row_r      <= tap_row_s;
            bias_r         <= bias_s;
            out_valid_r    <= out_valid_s;
            out_data_r     <= out_data_s;
            out_index_r    <= out_index_s;
            done_r         <= done_s;
            busy_r         <= (state_s != IDLE);
            tap_rd_en_r    <= tap_rd_en_s;
            tap_rd_addr_r  <= tap_rd_addr_s;
            bias_rd_en_r   <= bias_rd_en_s;
            bias_rd_addr_r <= bias_rd_addr_s;
            data_rd_en_r   <= data_rd_en_s;
            data_rd_addr_r <= data_rd_addr_s;
        end
    end

    assign busy         = busy_r;
    assign tap_rd_en    = tap_rd_en_r;
    assign tap_rd_addr  = tap_rd_addr_r;
    assign bias_rd_en   = bias_rd_en_r;
    assign bias_rd_addr = bias_rd_addr_r;
    assign data_rd_en   = data_rd_en_r;
    assign data_rd_addr = data_rd_addr_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_index    = out_index_r;
    assign done         = done_r;

endmodule

// File: tb/tb_four_12_12_st0_fwd.sv
// Scoreboard bench for four_12_12_st0_fwd: directed passes push hand-computed
// results into a queue; a monitor pops and compares on every output handshake.
module tb_four_12_12_st0_fwd;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         tap_rd_en;
    logic [4:0]   tap_rd_addr;
    logic [383:0] tap_rd_data = '0;
    logic         bias_rd_en;
    logic [3:0]   bias_rd_addr;
    logic [31:0]  bias_rd_data = '0;
    logic         data_rd_en;
    logic [8:0]   data_rd_addr;
    logic [31:0]  data_rd_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [3:0]   out_index;
    logic         done;

    four_12_12_st0_fwd dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .tap_rd_en(tap_rd_en), .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data),
        .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          res_in_pass = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    bit          timing_on = 1'b0;
    bit          stall_mode = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_index = '0;

    logic [31:0] tap_mem [0:11][0:11];
    logic [31:0] bias_mem [0:11];
    logic [31:0] data_mem [0:511];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memories answer one cycle after the strobe; otherwise they return junk.
    always @(posedge clk) begin
        if (tap_rd_en) begin
            for (int k = 0; k < 12; k++) tap_rd_data[32*k +: 32] <= tap_mem[tap_rd_addr[3:0]][k];
        end else begin
            tap_rd_data <= {12{32'hDEAD_BEEF}};
        end
        bias_rd_data <= bias_rd_en ? bias_mem[bias_rd_addr] : 32'hDEAD_BEEF;
        data_rd_data <= data_rd_en ? data_mem[data_rd_addr] : 32'hDEAD_BEEF;
    end

    // Downstream: in stall mode hold ready low for 5 cycles at each result.
    always @(posedge clk) begin
        #1;
        if (stall_mode && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else begin
            out_ready = 1'b1;
            if (!out_valid) stall_cnt = 0;
        end
    end

    // Monitor: checks results, stability under stall, timing and done.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) chk("no_read_in_out", {61'd0, tap_rd_en, bias_rd_en, data_rd_en}, 64'd0);
            if (out_valid && prev_valid && !prev_ready) begin
                chk("stall_data", {32'd0, out_data}, {32'd0, prev_data});
                chk("stall_index", {60'd0, out_index}, {60'd0, prev_index});
            end
            if (timing_on && out_valid && !prev_valid)
                chk("valid_timing", 64'(cyc - start_cyc), 64'(14 + 15 * res_in_pass));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got idx=%0d data=0x%0h expected no result", out_index, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", {32'd0, out_data}, {32'd0, mon_e.data});
                    chk("out_index", {60'd0, out_index}, {60'd0, mon_e.idx});
                end
                res_in_pass++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_index = out_index;
    end

    task automatic check_reset_zero(input string name);
        chk({name, "_ctrl"}, {58'd0, busy, tap_rd_en, bias_rd_en, data_rd_en, out_valid, done}, 64'd0);
        chk({name, "_addr"}, {46'd0, tap_rd_addr, bias_rd_addr, data_rd_addr}, 64'd0);
        chk({name, "_data"}, {28'd0, out_index, out_data}, 64'd0);
    endtask

    task automatic set_identity();
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 12; k++) tap_mem[n][k] = (k == n) ? 32'h0001_0000 : 32'h0;
            bias_mem[n] = 32'h0;
        end
        for (int i = 0; i < 12; i++) data_mem[i] = 32'(i + 1) << 16;
    endtask

    task automatic set_uniform(input logic [31:0] t, input logic [31:0] d, input logic [31:0] b);
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 12; k++) tap_mem[n][k] = t;
            bias_mem[n] = b;
        end
        for (int i = 0; i < 12; i++) data_mem[i] = d;
    endtask

    task automatic push_exp(input logic [31:0] d, input int n);
        exp_t e;
        e.data = d;
        e.idx  = 4'(n);
        exp_q.push_back(e);
    endtask

    task automatic push_identity();
        for (int n = 0; n < 12; n++) push_exp(32'(n + 1) << 16, n);
    endtask

    task automatic push_const(input logic [31:0] d);
        for (int n = 0; n < 12; n++) push_exp(d, n);
    endtask

    // Pulse start (optionally again at restart_at cycles), wait for done with a bound.
    task automatic run_pass(input bit stall, input int restart_at);
        int d0;
        stall_mode = stall;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        res_in_pass = 0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            start = (restart_at > 0 && (cyc - start_cyc) == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("results_left", 64'(exp_q.size()), 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        stall_mode = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) data_mem[i] = 32'h4BAD_0000 + 32'(i);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // identity with latency/throughput timing
        set_identity();
        push_identity();
        timing_on = 1'b1;
        run_pass(1'b0, 0);

        // second start pulse at cycle 30 must be ignored
        push_identity();
        run_pass(1'b0, 30);
        timing_on = 1'b0;

        // -1.0 taps * 1.0 data * 12 + 2.0 bias = -10.0
        set_uniform(32'hFFFF_0000, 32'h0001_0000, 32'h0002_0000);
        push_const(32'hFFF6_0000);
        run_pass(1'b0, 0);

        // positive and negative saturation
        set_uniform(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
        push_const(32'h7FFF_FFFF);
        run_pass(1'b0, 0);
        set_uniform(32'h8000_0001, 32'h7FFF_FFFF, 32'h0);
        push_const(32'h8000_0000);
        run_pass(1'b0, 0);

        // floor shift: 0.5 * 0xFFFF0001 = -32767.5 -> -32768, plus bias n.0
        set_uniform(32'h0, 32'h1234_5678, 32'h0);
        data_mem[0] = 32'hFFFF_0001;
        for (int n = 0; n < 12; n++) begin
            tap_mem[n][0] = 32'h0000_8000;
            bias_mem[n]   = 32'(n) << 16;
            push_exp((32'(n) << 16) - 32'h0000_8000, n);
        end
        run_pass(1'b0, 0);

        // backpressure
        set_identity();
        push_identity();
        run_pass(1'b1, 0);

        // reset during MAC of neuron 3
        push_identity();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        res_in_pass = 0;
        for (int i = 0; i < 500 && res_in_pass < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_zero("midreset");
        chk("aborted_left", 64'(exp_q.size()), 64'd9);
        @(negedge clk);
        check_reset_zero("midreset_hold");
        exp_q.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_valid", {62'd0, busy, out_valid}, 64'd0);
        push_identity();
        run_pass(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
